oai222_bist: RTL

Built-in self-test sequencer for a single OAI222 cell instance. It sits directly upstream of the cell, driving all six inputs through the 64 exhaustive vectors. It also consumes the cell's ZN output one stage downstream and compares it against a golden OAI222 function. Results are a mismatch count, the first failing vector and a pass flag, used for post-layout gate-level sign-off of the cell.

---
 rtl/oai222_bist_pkg.sv | 21 ++
 rtl/oai222_bist.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/oai222_bist_pkg.sv
// Shared types and the golden OAI222 function for the OAI222 cell self-test sequencer.
package oai222_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int NUM_VEC = 64;
  localparam int VEC_W   = 6;
  localparam int ERR_W   = 7;
  localparam int CNT_W   = 4;

  // Golden ZN for vector {A1,A2,B1,B2,C1,C2}.
  function automatic logic oai222_exp(input logic [VEC_W-1:0] v);
    return ~((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
  endfunction

endpackage

// File: rtl/oai222_bist.sv
// Exhaustive 64-vector self-test sequencer for one OAI222 cell: drives the inputs,
// compares ZN to the golden function, and reports error count and first failing vector.
module oai222_bist
  import oai222_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             C1,
  output logic             C2,
  input  logic             ZN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [VEC_W-1:0] FIRST_FAIL,
  output logic             FIRST_FAIL_VLD
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

  state_e             r_state;
  logic [VEC_W-1:0]   r_vec;
  logic [CNT_W-1:0]   r_cnt;
  logic [ERR_W-1:0]   r_err;
  logic [VEC_W-1:0]   r_ff;
  logic               r_ffv;
  logic [VEC_W-1:0]   r_stim;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;

  state_e             w_state_nxt;
  logic [VEC_W-1:0]   w_vec_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [ERR_W-1:0]   w_err_nxt;
  logic [VEC_W-1:0]   w_ff_nxt;
  logic               w_ffv_nxt;
  logic               w_busy_nxt;
  logic               w_mismatch;

  // Next-state, counter and result update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_ff_nxt    = r_ff;
    w_ffv_nxt   = r_ffv;
    // Case inequality so an X/Z on the cell output is never taken as a match.
    w_mismatch  = (ZN !== oai222_exp(r_vec));

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          w_state_nxt = ST_SETTLE;
          w_vec_nxt   = {VEC_W{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_err_nxt   = {ERR_W{1'b0}};
          w_ff_nxt    = {VEC_W{1'b0}};
          w_ffv_nxt   = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_SETTLE: begin
        w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_CHECK: begin
        if (w_mismatch) begin
          w_err_nxt = r_err + {{(ERR_W-1){1'b0}}, 1'b1};
          if (!r_ffv) begin
            w_ff_nxt  = r_vec;
            w_ffv_nxt = 1'b1;
          end else begin
            w_ff_nxt  = r_ff;
          end
        end else begin
          w_err_nxt = r_err;
        end
        if (r_vec == LAST_VEC) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_vec_nxt   = r_vec + {{(VEC_W-1){1'b0}}, 1'b1};
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = ST_SETTLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_CHECK);
  end

  // State, counters and registered outputs; reset discards any partial run.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_vec   <= {VEC_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_err   <= {ERR_W{1'b0}};
      r_ff    <= {VEC_W{1'b0}};
      r_ffv   <= 1'b0;
      r_stim  <= {VEC_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_ff    <= w_ff_nxt;
      r_ffv   <= w_ffv_nxt;
      r_stim  <= w_busy_nxt ? w_vec_nxt : {VEC_W{1'b0}};
      r_busy  <= w_busy_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
      r_pass  <= (w_state_nxt == ST_DONE) && (w_err_nxt == {ERR_W{1'b0}});
    end
  end

  assign {A1, A2, B1, B2, C1, C2} = r_stim;
  assign BUSY           = r_busy;
  assign DONE           = r_done;
  assign PASS           = r_pass;
  assign ERR_CNT        = r_err;
  assign FIRST_FAIL     = r_ff;
  assign FIRST_FAIL_VLD = r_ffv;

endmodule
